// File: rtl/video_pkg.sv
// Shared types, per-mode timing table and sync-window helper for the video timing generator.
package video_pkg;

   localparam int TW = 12;

   typedef enum logic [1:0] {
      MODE_VGA   = 2'd0,
      MODE_SVGA  = 2'd1,
      MODE_720P  = 2'd2,
      MODE_1080P = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } mode_state_t;

   typedef struct packed {
      logic [TW-1:0] h_act;
      logic [TW-1:0] h_fp;
      logic [TW-1:0] h_sync;
      logic [TW-1:0] h_bp;
      logic [TW-1:0] h_tot;
      logic [TW-1:0] v_act;
      logic [TW-1:0] v_fp;
      logic [TW-1:0] v_sync;
      logic [TW-1:0] v_bp;
      logic [TW-1:0] v_tot;
      logic          sync_pos;
   } timing_t;

   localparam timing_t TIMING [4] = '{
      '{12'd640,  12'd16,  12'd96,  12'd48,  12'd800,  12'd480,  12'd10, 12'd2, 12'd33, 12'd525,  1'b0},
      '{12'd800,  12'd40,  12'd128, 12'd88,  12'd1056, 12'd600,  12'd1,  12'd4, 12'd23, 12'd628,  1'b1},
      '{12'd1280, 12'd110, 12'd40,  12'd220, 12'd1650, 12'd720,  12'd5,  12'd5, 12'd20, 12'd750,  1'b1},
      '{12'd1920, 12'd88,  12'd44,  12'd148, 12'd2200, 12'd1080, 12'd4,  12'd5, 12'd36, 12'd1125, 1'b1}
   };

   // Sync window follows active + front porch; vert selects the vertical fields.
   function automatic logic sync_active(input logic [TW-1:0] cnt, input timing_t t, input logic vert);
      logic [TW-1:0] start;
      logic [TW-1:0] len;
      start = vert ? (t.v_act + t.v_fp) : (t.h_act + t.h_fp);
      len   = vert ? t.v_sync : t.h_sync;
      return (cnt >= start) && (cnt < start + len);
   endfunction

endpackage

// File: rtl/pipe_dly.sv
// Fixed-depth register delay line with a per-bit reset value; DEPTH of 0 is a plain wire.
module pipe_dly #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ reset_n;
         assign q = d;
      end else begin : g_regs
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
               stage[0] <= d;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode video timing generator: h/v counters, frame-boundary mode switching,
// polarity-corrected sync/DE/strobes delayed by PIPE_DLY stages.
module video_timing_gen
   import video_pkg::*;
#(
   parameter int CNT_W      = 12,
   parameter int PIPE_DLY   = 2,
   parameter int RESET_MODE = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [1:0]       mode_sel,
   input  logic             mode_req,
   output logic             mode_ack,
   output mode_t            cur_mode,
   output logic [CNT_W-1:0] h_pos,
   output logic [CNT_W-1:0] v_pos,
   output logic             de,
   output logic             hsync,
   output logic             vsync,
   output logic             line_start,
   output logic             frame_start,
   output mode_state_t      fsm_state
);

   localparam mode_t            RST_MODE = mode_t'(RESET_MODE[1:0]);
   localparam logic             RST_SYNC = ~TIMING[RESET_MODE].sync_pos;
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0] h_cnt, v_cnt, h_nx, v_nx;
   logic             run;
   mode_t            pend, mode_nx;
   mode_state_t      state;
   timing_t          t_cur, t_nx;
   logic             h_last, v_last, frame_end;
   logic             de_nx, hs_nx, vs_nx, ls_nx, fs_nx;
   logic             de_s0, hs_s0, vs_s0, ls_s0, fs_s0;
   logic [4:0]       dly_q;

   // run stays low until the first enabled cycle after reset so pixel (0,0) is emitted once.
   always_comb begin
      t_cur     = TIMING[cur_mode];
      h_last    = (h_cnt == CNT_W'(t_cur.h_tot) - ONE);
      v_last    = (v_cnt == CNT_W'(t_cur.v_tot) - ONE);
      frame_end = enable && run && h_last && v_last;
      mode_nx   = (frame_end && state == ST_PENDING) ? pend : cur_mode;
      t_nx      = TIMING[mode_nx];

      h_nx = h_cnt;
      v_nx = v_cnt;
      if (enable && run) begin
         if (h_last) begin
            h_nx = '0;
            v_nx = v_last ? '0 : v_cnt + ONE;
         end else begin
            h_nx = h_cnt + ONE;
         end
      end

      de_nx = enable && (h_nx < CNT_W'(t_nx.h_act)) && (v_nx < CNT_W'(t_nx.v_act));
      hs_nx = (enable && sync_active(h_nx[TW-1:0], t_nx, 1'b0)) ? t_nx.sync_pos : ~t_nx.sync_pos;
      vs_nx = (enable && sync_active(v_nx[TW-1:0], t_nx, 1'b1)) ? t_nx.sync_pos : ~t_nx.sync_pos;
      ls_nx = enable && (h_nx == '0);
      fs_nx = ls_nx && (v_nx == '0);
   end

   // Stage-0 flags are registered together with the counters, so they align with h_pos/v_pos.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
         run   <= 1'b0;
         de_s0 <= 1'b0;
         hs_s0 <= RST_SYNC;
         vs_s0 <= RST_SYNC;
         ls_s0 <= 1'b0;
         fs_s0 <= 1'b0;
      end else begin
         h_cnt <= h_nx;
         v_cnt <= v_nx;
         if (enable) run <= 1'b1;
         de_s0 <= de_nx;
         hs_s0 <= hs_nx;
         vs_s0 <= vs_nx;
         ls_s0 <= ls_nx;
         fs_s0 <= fs_nx;
      end
   end

   // Handshake: mode_req is a one-cycle strobe sampled while enable is high (latest request wins);
   // mode_ack pulses once, in the first cycle of the new frame that runs with the applied mode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         pend     <= RST_MODE;
         cur_mode <= RST_MODE;
         mode_ack <= 1'b0;
      end else begin
         mode_ack <= 1'b0;
         if (enable) begin
            case (state)
               ST_IDLE: begin
                  if (mode_req) begin
                     pend  <= mode_t'(mode_sel);
                     state <= ST_PENDING;
                  end
               end
               ST_PENDING: begin
                  if (mode_req) pend <= mode_t'(mode_sel);
                  if (frame_end) begin
                     cur_mode <= pend;
                     mode_ack <= 1'b1;
                     if (!mode_req) state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   pipe_dly #(
      .WIDTH   (5),
      .DEPTH   (PIPE_DLY),
      .RST_VAL ({1'b0, RST_SYNC, RST_SYNC, 2'b00})
   ) u_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .d       ({de_s0, hs_s0, vs_s0, ls_s0, fs_s0}),
      .q       (dly_q)
   );

   assign {de, hsync, vsync, line_start, frame_start} = dly_q;
   assign h_pos     = h_cnt;
   assign v_pos     = v_cnt;
   assign fsm_state = state;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: one instance with PIPE_DLY=0 and one with PIPE_DLY=3.
module tb_video_timing_gen;
   import video_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  mode_sel = 2'd0;
   logic        mode_req = 1'b0;

   logic        ack0, de0, hs0, vs0, ls0, fs0;
   mode_t       cur0;
   mode_state_t st0;
   logic [11:0] h0, v0;
   logic        ack3, de3, hs3, vs3, ls3, fs3;
   mode_t       cur3;
   mode_state_t st3;
   logic [11:0] h3, v3;

   int          n_assert = 0;
   int          n_fail = 0;
   int          bad;
   int          acks;
   logic [11:0] jmp_h, jmp_v;

   always #5 clk = ~clk;

   video_timing_gen #(.CNT_W(12), .PIPE_DLY(0), .RESET_MODE(2)) dut0 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode_sel(mode_sel), .mode_req(mode_req),
      .mode_ack(ack0), .cur_mode(cur0), .h_pos(h0), .v_pos(v0), .de(de0), .hsync(hs0),
      .vsync(vs0), .line_start(ls0), .frame_start(fs0), .fsm_state(st0)
   );

   video_timing_gen #(.CNT_W(12), .PIPE_DLY(3), .RESET_MODE(2)) dut3 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode_sel(mode_sel), .mode_req(mode_req),
      .mode_ack(ack3), .cur_mode(cur3), .h_pos(h3), .v_pos(v3), .de(de3), .hsync(hs3),
      .vsync(vs3), .line_start(ls3), .frame_start(fs3), .fsm_state(st3)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_pos(input string tag, input int h, input int v, input int budget);
      int k;
      k = 0;
      while (!(h0 == 12'(h) && v0 == 12'(v)) && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_reached"}, 32'(h0 == 12'(h) && v0 == 12'(v)), 32'd1);
   endtask

   // Moves both counters deep into a frame so frame-end behaviour is reachable quickly.
   task automatic jump(input int h, input int v);
      jmp_h = 12'(h);
      jmp_v = 12'(v);
      @(negedge clk);
      force dut0.h_cnt = jmp_h;
      force dut0.v_cnt = jmp_v;
      force dut3.h_cnt = jmp_h;
      force dut3.v_cnt = jmp_v;
      @(negedge clk);
      release dut0.h_cnt;
      release dut0.v_cnt;
      release dut3.h_cnt;
      release dut3.v_cnt;
      tick();
   endtask

   // Two full lines starting at h_pos=0 of an active row.
   task automatic measure(input string tag, input int tot, input logic pol, input int act_start,
                          input int width, input int h_act);
      int   de_cnt, act_cnt, r1, r2, rise_h;
      logic prev;
      de_cnt = 0; act_cnt = 0; r1 = -1; r2 = -1; rise_h = -1;
      prev = (hs0 == pol);
      for (int i = 0; i < 2 * tot; i++) begin
         tick();
         if (de0) de_cnt++;
         if (hs0 == pol) begin
            act_cnt++;
            if (!prev) begin
               if (r1 < 0) begin
                  r1 = i;
                  rise_h = int'(h0);
               end else if (r2 < 0) begin
                  r2 = i;
               end
            end
         end
         prev = (hs0 == pol);
      end
      check({tag, "_de_count"}, de_cnt, 2 * h_act);
      check({tag, "_hsync_width"}, act_cnt, 2 * width);
      check({tag, "_hsync_period"}, r2 - r1, tot);
      check({tag, "_hsync_start"}, rise_h, act_start);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      reset_n = 1'b0;
      enable  = 1'b1;
      tick(2);
      check("rst_h", h0, 0);
      check("rst_v", v0, 0);
      check("rst_mode", cur0, 2);
      check("rst_state", st0, ST_IDLE);
      check("rst_flags0", {ack0, de0, hs0, vs0, ls0, fs0}, 0);
      check("rst_flags3", {ack3, de3, hs3, vs3, ls3, fs3}, 0);
      check("rst_pos3", {h3, v3}, 0);
      check("rst_mode3", {cur3, st3}, {2'd2, ST_IDLE});

      // Release: (0,0) with frame_start, delayed copy 3 cycles later
      reset_n = 1'b1;
      tick();
      check("start_h", h0, 0);
      check("start_de_ls_fs", {de0, ls0, fs0}, 3'b111);
      check("start_fs3_early", fs3, 0);
      tick(2);
      check("dly3_de_before", {de3, fs3}, 2'b00);
      tick();
      check("dly3_h", h0, 3);
      check("dly3_de_fs", {de3, fs3}, 2'b11);
      tick();
      check("dly3_fs_pulse", {de3, fs3}, 2'b10);

      // Mode 2 line timing
      wait_pos("m2_line1", 0, 1, 2000);
      measure("m2", 1650, 1'b1, 1390, 40, 1280);

      // Mode 2 vertical edges
      jump(1270, 719);
      wait_pos("m2_de_last", 1279, 719, 100);
      check("m2_de_last", de0, 1);
      tick();
      check("m2_de_off", de0, 0);
      wait_pos("m2_blank", 0, 720, 500);
      check("m2_blank_de_vs", {de0, vs0}, 2'b00);
      jump(1640, 724);
      wait_pos("m2_vs_pre", 1649, 724, 100);
      check("m2_vs_pre", vs0, 0);
      tick();
      check("m2_vs_rise", {v0, vs0}, {12'd725, 1'b1});
      jump(1640, 729);
      wait_pos("m2_vs_last", 1649, 729, 100);
      check("m2_vs_last", vs0, 1);
      tick();
      check("m2_vs_fall", {v0, vs0}, {12'd730, 1'b0});

      // Mid-frame request for mode 0
      mode_sel = 2'd0;
      mode_req = 1'b1;
      tick();
      mode_req = 1'b0;
      check("req0_pending", {st0, cur0}, {ST_PENDING, 2'd2});
      jump(1640, 749);
      wait_pos("req0_frame_end", 1649, 749, 100);
      check("req0_before", {cur0, ack0}, {2'd2, 1'b0});
      tick();
      check("req0_pos", {h0, v0}, 0);
      check("req0_switch", {cur0, ack0, fs0, st0}, {2'd0, 1'b1, 1'b1, ST_IDLE});
      check("req0_pol", {hs0, vs0}, 2'b11);
      tick();
      check("req0_ack_pulse", ack0, 0);
      wait_pos("m0_line1", 0, 1, 900);
      measure("m0", 800, 1'b0, 656, 96, 640);

      // Two requests in one frame: only the last applies
      mode_sel = 2'd1;
      mode_req = 1'b1;
      tick();
      mode_req = 1'b0;
      tick(5);
      mode_sel = 2'd3;
      mode_req = 1'b1;
      tick();
      mode_req = 1'b0;
      jump(790, 524);
      wait_pos("req13_end", 799, 524, 100);
      check("req13_before", {cur0, ack0}, {2'd0, 1'b0});
      tick();
      check("req13_switch", {cur0, ack0, hs0}, {2'd3, 1'b1, 1'b0});
      acks = 0;
      repeat (20) begin
         tick();
         if (ack0) acks++;
      end
      check("req13_single_ack", {acks[7:0], st0}, {8'd0, ST_IDLE});
      wait_pos("m3_line1", 0, 1, 2300);
      measure("m3", 2200, 1'b1, 2008, 44, 1920);

      // Request in the exact frame-end cycle waits one more frame
      jump(2190, 1124);
      wait_pos("fe_req", 2199, 1124, 100);
      mode_sel = 2'd1;
      mode_req = 1'b1;
      tick();
      mode_req = 1'b0;
      check("fe_no_switch", {h0, v0, cur0, ack0, st0}, {24'd0, 2'd3, 1'b0, ST_PENDING});
      jump(2190, 1124);
      wait_pos("fe_next", 2199, 1124, 100);
      check("fe_next_before", cur0, 3);
      tick();
      check("fe_switch", {cur0, ack0, st0}, {2'd1, 1'b1, ST_IDLE});

      // Request equal to the current mode still acknowledges
      mode_sel = 2'd1;
      mode_req = 1'b1;
      tick();
      mode_req = 1'b0;
      jump(1050, 627);
      wait_pos("same_end", 1055, 627, 100);
      tick();
      check("same_ack", {cur0, ack0, h0, v0}, {2'd1, 1'b1, 24'd0});

      // enable low mid-line
      wait_pos("en_de", 100, 0, 200);
      check("en_de_before", de0, 1);
      enable = 1'b0;
      bad = 0;
      repeat (100) begin
         tick();
         if (h0 !== 12'd100 || de0 !== 1'b0 || hs0 !== 1'b0 || vs0 !== 1'b0) bad++;
      end
      check("en_hold", bad, 0);
      check("en_hold_dly3", de3, 0);
      enable = 1'b1;
      tick();
      check("en_resume", {h0, de0}, {12'd101, 1'b1});
      wait_pos("en_hs", 900, 0, 1000);
      check("en_hs_before", hs0, 1);
      enable = 1'b0;
      tick();
      check("en_hs_forced", {h0, hs0}, {12'd900, 1'b0});
      tick(3);
      check("en_hs_forced3", hs3, 0);
      enable = 1'b1;

      // Asynchronous reset mid-frame with a request pending
      mode_sel = 2'd0;
      mode_req = 1'b1;
      tick();
      mode_req = 1'b0;
      tick(10);
      check("arst_pre", {st0, hs0}, {ST_PENDING, 1'b1});
      reset_n = 1'b0;
      #2;
      check("arst_pos", {h0, v0}, 0);
      check("arst_mode", {cur0, st0}, {2'd2, ST_IDLE});
      check("arst_flags0", {ack0, de0, hs0, vs0, ls0, fs0}, 0);
      check("arst_flags3", {de3, hs3, vs3, fs3}, 0);
      tick(2);
      reset_n = 1'b1;
      tick();
      check("arst_restart", {h0, v0, fs0, cur0}, {24'd0, 1'b1, 2'd2});
      tick();
      check("arst_count", {h0, st0}, {12'd1, ST_IDLE});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
